// File: rtl/systolic_pkg.sv
// systolic_pkg: feeder FSM state type and default array dimensions shared with the array top
package systolic_pkg;
    typedef enum logic [2:0] {IDLE, CLR, FEED, FLUSH, DONE} feed_state_t;
    localparam int DEF_D_W = 8;
    localparam int DEF_N = 4;
endpackage

// File: rtl/skew_line.sv
// skew_line: DEPTH-stage reset-clearable delay of a data+valid pair; DEPTH=0 is a plain wire
module skew_line
    import systolic_pkg::*;
#(
    parameter int D_W = DEF_D_W,
    parameter int DEPTH = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [D_W-1:0] d,
    input  logic           v,
    output logic [D_W-1:0] q,
    output logic           qv
);
    generate
        if (DEPTH == 0) begin : g_wire
            logic unused;
            assign unused = clk | rst;
            assign q = d;
            assign qv = v;
        end else begin : g_sr
            logic [D_W:0] sr [DEPTH];
            always_ff @(posedge clk)
                if (rst) begin
                    for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
                end else begin
                    sr[0] <= {v, d};
                    for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
                end
            assign {qv, q} = sr[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: skews X/W tile beats onto the edge lanes of an N x N array; FEEDER_BUBBLE_CNT_EN adds O_BUBBLE_CNT
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int D_W = DEF_D_W,
    parameter int N = DEF_N,
    parameter int LEN_W = 8
) (
    input  logic             I_CLK,
    input  logic             I_SYNC_RST,
    input  logic             I_START,
    input  logic [LEN_W-1:0] I_LEN,
    input  logic             I_VLD,
    output logic             O_RDY,
    input  logic [N*D_W-1:0] I_X_VEC,
    input  logic [N*D_W-1:0] I_W_VEC,
    output logic [N*D_W-1:0] O_X,
    output logic [N*D_W-1:0] O_W,
    output logic [N-1:0]     O_VLD,
    output logic             O_CLR_N,
    output logic             O_BUSY,
    output logic             O_DONE
`ifdef FEEDER_BUBBLE_CNT_EN
    ,
    output logic [15:0]      O_BUBBLE_CNT
`endif
);
    localparam int FL_W = $clog2(2 * N);
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(2 * N - 3);
    feed_state_t state;
    logic [LEN_W-1:0] len, cnt, cnt_nxt;
    logic [FL_W-1:0] fcnt;
    logic [N*D_W-1:0] inj_x, inj_w;
    logic inj_v, beat;
    assign cnt_nxt = cnt + 1'b1;
    assign beat = state == FEED && I_VLD && O_RDY;
    always_ff @(posedge I_CLK)
        if (I_SYNC_RST) begin
            state <= IDLE;
            len <= '0;
            cnt <= '0;
            fcnt <= '0;
            O_RDY <= 1'b0;
            O_BUSY <= 1'b0;
            O_DONE <= 1'b0;
            O_CLR_N <= 1'b1;
        end else begin
            O_DONE <= 1'b0;
            O_CLR_N <= 1'b1;
            case (state)
                IDLE: if (I_START) begin
                    state <= CLR;
                    len <= I_LEN;
                    cnt <= '0;
                    O_BUSY <= 1'b1;
                    O_CLR_N <= 1'b0;
                end
                CLR: begin
                    fcnt <= '0;
                    state <= len != '0 ? FEED : FLUSH;
                    O_RDY <= len != '0;
                end
                FEED: if (beat) begin
                    cnt <= cnt_nxt;
                    if (cnt_nxt == len) begin
                        state <= FLUSH;
                        O_RDY <= 1'b0;
                    end
                end
                FLUSH: if (fcnt == FL_LAST) begin
                    state <= DONE;
                    O_DONE <= 1'b1;
                end else fcnt <= fcnt + 1'b1;
                DONE: begin
                    state <= IDLE;
                    O_BUSY <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    // Bubbles and flush beats carry valid with zero data so the wavefront stays aligned
    always_ff @(posedge I_CLK)
        if (I_SYNC_RST) begin
            inj_x <= '0;
            inj_w <= '0;
            inj_v <= 1'b0;
        end else begin
            inj_x <= beat ? I_X_VEC : '0;
            inj_w <= beat ? I_W_VEC : '0;
            inj_v <= state == FEED || state == FLUSH;
        end
`ifdef FEEDER_BUBBLE_CNT_EN
    always_ff @(posedge I_CLK)
        if (I_SYNC_RST || state == CLR) O_BUBBLE_CNT <= '0;
        else if (state == FEED && !I_VLD && O_BUBBLE_CNT != 16'hFFFF) O_BUBBLE_CNT <= O_BUBBLE_CNT + 1'b1;
`endif
    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_line #(.D_W(2 * D_W), .DEPTH(i)) u_skew (
            .clk(I_CLK),
            .rst(I_SYNC_RST),
            .d({inj_w[i*D_W +: D_W], inj_x[i*D_W +: D_W]}),
            .v(inj_v),
            .q({O_W[i*D_W +: D_W], O_X[i*D_W +: D_W]}),
            .qv(O_VLD[i])
        );
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: table, directed and randomized checks of systolic_feeder against a tile-timeline model
module tb_systolic_feeder;
    localparam int N = 4;
    localparam int T = 512;
    logic clk = 1'b0;
    logic rst, start, vld, rdy, clr_n, busy, done;
    logic [7:0] tile_len;
    logic [31:0] x_vec, w_vec, x_edge, w_edge;
    logic [3:0] lane_vld;
`ifdef FEEDER_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt;
`endif
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_at, done_cnt, rdy_cnt;
    logic [7:0] hist [T];
    bit st [T];
    bit vl [T];
    logic [7:0] ln [T];
    logic [31:0] xv [T];
    logic [31:0] wv [T];

    systolic_feeder #(.D_W(8), .N(N), .LEN_W(8)) dut (
        .I_CLK(clk),
        .I_SYNC_RST(rst),
        .I_START(start),
        .I_LEN(tile_len),
        .I_VLD(vld),
        .O_RDY(rdy),
        .I_X_VEC(x_vec),
        .I_W_VEC(w_vec),
        .O_X(x_edge),
        .O_W(w_edge),
        .O_VLD(lane_vld),
        .O_CLR_N(clr_n),
        .O_BUSY(busy),
        .O_DONE(done)
`ifdef FEEDER_BUBBLE_CNT_EN
        ,
        .O_BUBBLE_CNT(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        start = 1'b1;
        tile_len = 8'd5;
        vld = 1'b1;
        x_vec = '1;
        w_vec = '1;
        tick;
        tick;
        cyc = -1;
        chk("rst_x", x_edge, 0);
        chk("rst_w", w_edge, 0);
        chk("rst_vld", 32'(lane_vld), 0);
        chk("rst_rdy", 32'(rdy), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_clr_n", 32'(clr_n), 1);
        rst = 1'b0;
        start = 1'b0;
        vld = 1'b0;
        x_vec = '0;
        w_vec = '0;
    endtask

    task automatic clear_plan;
        for (int t = 0; t < T; t++) begin
            st[t] = 1'b0;
            vl[t] = 1'b1;
            ln[t] = 8'd0;
            xv[t] = $urandom;
            wv[t] = $urandom;
        end
    endtask

    // Expected timeline per tile: CLR, FEED until len beats accepted, 2N-2 flush, DONE
    task automatic run_plan(input int sim);
        logic [31:0] ix [T];
        logic [31:0] iw [T];
        bit iv [T];
        bit er [T];
        bit eb [T];
        bit ed [T];
        bit ec [T];
        logic [31:0] ex, ew;
        logic [3:0] ev;
        int c, k, a, d;
        for (int t = 0; t < T; t++) begin
            ix[t] = 0; iw[t] = 0; iv[t] = 0; er[t] = 0; eb[t] = 0; ed[t] = 0; ec[t] = 1;
        end
        c = 0;
        while (c < sim) begin
            if (!st[c]) begin
                c++;
                continue;
            end
            ec[c+1] = 0;
            k = c + 2;
            a = 0;
            while (a < int'(ln[c]) && k < T - 2 * N) begin
                er[k] = 1;
                iv[k] = 1;
                if (vl[k]) begin
                    ix[k] = xv[k];
                    iw[k] = wv[k];
                    a++;
                end
                k++;
            end
            for (int f = 0; f < 2 * N - 2; f++) iv[k+f] = 1;
            d = k + 2 * N - 2;
            ed[d] = 1;
            for (int b = c + 1; b <= d; b++) eb[b] = 1;
            c = d + 1;
        end
        do_reset;
        done_at = -1;
        done_cnt = 0;
        rdy_cnt = 0;
        for (int t = 0; t < sim; t++) begin
            cyc = t;
            ex = 0; ew = 0; ev = 0;
            for (int i = 0; i < N; i++)
                if (t - 1 - i >= 0) begin
                    ex[i*8 +: 8] = ix[t-1-i][i*8 +: 8];
                    ew[i*8 +: 8] = iw[t-1-i][i*8 +: 8];
                    ev[i] = iv[t-1-i];
                end
            chk("x", x_edge, ex);
            chk("w", w_edge, ew);
            chk("vld", 32'(lane_vld), 32'(ev));
            chk("rdy", 32'(rdy), 32'(er[t]));
            chk("busy", 32'(busy), 32'(eb[t]));
            chk("done", 32'(done), 32'(ed[t]));
            chk("clr_n", 32'(clr_n), 32'(ec[t]));
            hist[t] = x_edge[7:0];
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = t;
            end
            rdy_cnt += int'(rdy);
            start = st[t];
            tile_len = ln[t];
            vld = vl[t];
            x_vec = xv[t];
            w_vec = wv[t];
            tick;
        end
    endtask

    typedef struct {
        int st, ln, vl, x, clrn, rdy, busy, done, x0, v0, x3, v3;
    } vec_t;

    initial begin
        vec_t tv [16];
        logic [7:0] l0 [5];
        int got;
        rst = 1'b0; start = 1'b0; vld = 1'b0; tile_len = '0; x_vec = '0; w_vec = '0;
        tv[0]  = '{1, 3, 1, 'h00, 1, 0, 0, 0, 'h00, 0, 'h00, 0};
        tv[1]  = '{0, 0, 1, 'h00, 0, 0, 1, 0, 'h00, 0, 'h00, 0};
        tv[2]  = '{0, 0, 1, 'h11, 1, 1, 1, 0, 'h00, 0, 'h00, 0};
        tv[3]  = '{0, 0, 1, 'h22, 1, 1, 1, 0, 'h11, 1, 'h00, 0};
        tv[4]  = '{0, 0, 1, 'h33, 1, 1, 1, 0, 'h22, 1, 'h00, 0};
        tv[5]  = '{0, 0, 0, 'h00, 1, 0, 1, 0, 'h33, 1, 'h00, 0};
        tv[6]  = '{0, 0, 0, 'h00, 1, 0, 1, 0, 'h00, 1, 'h11, 1};
        tv[7]  = '{0, 0, 0, 'h00, 1, 0, 1, 0, 'h00, 1, 'h22, 1};
        tv[8]  = '{0, 0, 0, 'h00, 1, 0, 1, 0, 'h00, 1, 'h33, 1};
        tv[9]  = '{0, 0, 0, 'h00, 1, 0, 1, 0, 'h00, 1, 'h00, 1};
        tv[10] = '{0, 0, 0, 'h00, 1, 0, 1, 0, 'h00, 1, 'h00, 1};
        tv[11] = '{0, 0, 0, 'h00, 1, 0, 1, 1, 'h00, 1, 'h00, 1};
        tv[12] = '{0, 0, 0, 'h00, 1, 0, 0, 0, 'h00, 0, 'h00, 1};
        tv[13] = '{0, 0, 0, 'h00, 1, 0, 0, 0, 'h00, 0, 'h00, 1};
        tv[14] = '{0, 0, 0, 'h00, 1, 0, 0, 0, 'h00, 0, 'h00, 1};
        tv[15] = '{0, 0, 0, 'h00, 1, 0, 0, 0, 'h00, 0, 'h00, 0};
        do_reset;
        for (int r = 0; r < 16; r++) begin
            cyc = r;
            chk("tbl_clr_n", 32'(clr_n), tv[r].clrn);
            chk("tbl_rdy", 32'(rdy), tv[r].rdy);
            chk("tbl_busy", 32'(busy), tv[r].busy);
            chk("tbl_done", 32'(done), tv[r].done);
            chk("tbl_x0", 32'(x_edge[7:0]), tv[r].x0);
            chk("tbl_w0", 32'(w_edge[7:0]), tv[r].x0);
            chk("tbl_v0", 32'(lane_vld[0]), tv[r].v0);
            chk("tbl_x3", 32'(x_edge[31:24]), tv[r].x3);
            chk("tbl_v3", 32'(lane_vld[3]), tv[r].v3);
            start = tv[r].st[0];
            tile_len = 8'(tv[r].ln);
            vld = tv[r].vl[0];
            x_vec = {4{8'(tv[r].x)}};
            w_vec = {4{8'(tv[r].x)}};
            tick;
        end
        // two-cycle input stall mid-tile
        clear_plan;
        st[0] = 1'b1; ln[0] = 8'd3; vl[3] = 1'b0; vl[4] = 1'b0;
        xv[2] = {4{8'h11}}; xv[5] = {4{8'h22}}; xv[6] = {4{8'h33}};
        run_plan(30);
        l0 = '{8'h11, 8'h00, 8'h00, 8'h22, 8'h33};
        for (int i = 0; i < 5; i++) begin
            cyc = 3 + i;
            chk("stall_lane0", 32'(hist[3+i]), 32'(l0[i]));
        end
        chk("stall_done_cycle", done_at, 13);
        chk("stall_done_count", done_cnt, 1);
`ifdef FEEDER_BUBBLE_CNT_EN
        chk("stall_bubbles", 32'(bubble_cnt), 2);
`endif
        // zero-length tile
        clear_plan;
        st[0] = 1'b1; ln[0] = 8'd0;
        run_plan(20);
        chk("len0_done_cycle", done_at, 8);
        chk("len0_rdy_cycles", rdy_cnt, 0);
        chk("len0_done_count", done_cnt, 1);
        // second start during FLUSH is ignored
        clear_plan;
        st[0] = 1'b1; ln[0] = 8'd2; st[7] = 1'b1; ln[7] = 8'd4;
        run_plan(30);
        chk("restart_done_cycle", done_at, 10);
        chk("restart_done_count", done_cnt, 1);
        // reset mid-FEED, then a normal one-beat tile
        do_reset;
        cyc = 0;
        start = 1'b1; tile_len = 8'd5; vld = 1'b1; x_vec = 32'hA5A5A5A5; w_vec = 32'h5A5A5A5A;
        tick;
        start = 1'b0;
        tick;
        tick;
        tick;
        cyc = 4;
        chk("midfeed_rdy", 32'(rdy), 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        cyc = 5;
        chk("midrst_vld", 32'(lane_vld), 0);
        chk("midrst_x", x_edge, 0);
        chk("midrst_w", w_edge, 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_rdy", 32'(rdy), 0);
        chk("midrst_clr_n", 32'(clr_n), 1);
        start = 1'b1; tile_len = 8'd1;
        tick;
        start = 1'b0;
        got = 0;
        for (int j = 1; j <= 30; j++) begin
            if (done) begin
                got = j;
                break;
            end
            tick;
        end
        chk("midrst_restart_done", got, 9);
        // randomized tiles
        for (int p = 0; p < 2; p++) begin
            clear_plan;
            for (int c = 0; c < 250; c++) begin
                st[c] = $urandom_range(7) == 0;
                ln[c] = 8'($urandom_range(12));
                vl[c] = $urandom_range(3) != 0;
            end
            run_plan(320);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter D_W, default 8, element width (matches PE data width).
REQ-002 SHALL have parameter N, default 4, array edge size (number of lanes).
REQ-003 SHALL have parameter LEN_W, default 8, width of tile-length field.
REQ-004 Clocking and reset are fixed: one clock; reset is synchronous and active-high.
REQ-005 Ports SHALL be, in order:
- I_CLK  in  1  clock.
- I_SYNC_RST  in  1  synchronous active-high reset.
- I_START  in  1  tile start request.
- I_LEN  in  LEN_W  beats (K depth) in the tile.
- I_VLD  in  1  input beat valid.
- O_RDY  out  1  input beat accepted when I_VLD&O_RDY.
- I_X_VEC  in  N*D_W  one X element per row lane; lane i at [i*D_W +: D_W].
- I_W_VEC  in  N*D_W  one W element per column lane.
- O_X  out  N*D_W  skewed X to the left-edge PEs.
- O_W  out  N*D_W  skewed W to the top-edge PEs.
- O_VLD  out  N  per-lane valid to the edge PEs.
- O_CLR_N  out  1  active-low accumulator clear to the array's PE sync-reset input.
- O_BUSY  out  1  high in any state except IDLE.
- O_DONE  out  1  single-cycle tile-complete pulse.

Function
REQ-006 FSM states SHALL be IDLE, CLR, FEED, FLUSH and DONE.
REQ-007 IDLE: I_START=1 SHALL go to CLR and latch I_LEN; I_START outside IDLE SHALL be ignored.
REQ-008 CLR: SHALL last exactly 1 cycle with O_CLR_N=0, then go to FEED (latched length>0) or FLUSH (length=0).
REQ-009 FEED: O_RDY SHALL be 1; each I_VLD&O_RDY cycle SHALL inject the input vectors and increment the beat counter.
REQ-010 FEED with I_VLD=0: SHALL inject an all-zero bubble with injection valid=1, so the wavefront stays aligned and accumulation is unaffected.
REQ-011 FEED SHALL go to FLUSH in the cycle after the beat counter reaches the latched length; O_RDY SHALL be 0 from that cycle.
REQ-012 FLUSH: SHALL inject zeros with valid=1 for exactly 2N-2 cycles, then go to DONE.
REQ-013 DONE: O_DONE=1 for 1 cycle, then IDLE.
REQ-014 Injection stage SHALL be registered; lane i of O_X, O_W and O_VLD SHALL appear 1+i cycles after injection (lane 0: 1 cycle).
REQ-015 In IDLE, CLR and DONE, injection SHALL be zero data with valid=0; delay lines SHALL keep draining.
REQ-016 No arithmetic on data; beat counter SHALL be LEN_W bits, with no wrap within a tile.

Reset
REQ-017 I_SYNC_RST=1 SHALL, at the next edge, force IDLE and set O_X=0, O_W=0, O_VLD=0, O_RDY=0, O_BUSY=0, O_DONE=0, O_CLR_N=1, clear all delay-line stages and clear the counters.
REQ-018 Reset SHALL take priority over every event, including mid-FEED and mid-FLUSH, and over a simultaneous I_START.

Configuration
REQ-019 Macro FEEDER_BUBBLE_CNT_EN defined SHALL add output O_BUBBLE_CNT (16 bits): a count of REQ-010 bubbles, cleared in CLR, saturating at 16'hFFFF, held until the next CLR.
REQ-020 Without FEEDER_BUBBLE_CNT_EN, the port and the counter SHALL be absent; all other behaviour is identical.

Structure
REQ-021 Package systolic_pkg SHALL hold the FSM state enum typedef and the default D_W/N constants, shared with the array top.
REQ-022 Sub-module skew_line (parameters D_W and DEPTH; reset-clearable shift register carrying data+valid) SHALL be instantiated per lane with DEPTH=i; DEPTH=0 is a wire.

Verification (N=4, D_W=8, LEN_W=8)
REQ-023 Reset held 2 cycles -> all outputs 0, O_CLR_N=1, state IDLE; I_START asserted together with reset is ignored.
REQ-024 I_START at cycle 0, I_LEN=3, I_VLD=1 constant, lane elements 8'h11/8'h22/8'h33 -> O_CLR_N=0 at cycle 1; O_RDY=1 at cycles 2-4; lane0 O_X 11,22,33 at cycles 3-5; lane3 O_X 11,22,33 at cycles 6-8; FLUSH for 6 cycles; single O_DONE at cycle 11.
REQ-025 Same as REQ-024 but I_VLD=0 at cycles 3-4 -> lane0 O_X 11,00,00,22,33 with O_VLD=1 throughout; O_DONE delayed to cycle 13; O_BUBBLE_CNT=2 (macro on).
REQ-026 I_LEN=0 -> CLR, then 6 FLUSH cycles, then O_DONE, with O_RDY never asserted.
REQ-027 I_SYNC_RST pulsed during FEED at beat 2 of 5 -> IDLE next cycle with all lanes and O_VLD at 0; a following I_START with I_LEN=1 completes normally.
REQ-028 Second I_START during FLUSH -> ignored; exactly one O_DONE.
